// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_NREGS = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Low bit index of lane k in a bus flattened from w-bit lanes.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_clear_ctl.sv
// Post-reset clear sequencer: walks entries 1..NREGS-1 writing zero, then
// hands the array over to normal operation until the next reset.
module regfile_clear_ctl
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          ready_o,
    output logic          init_busy_o
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset is folded in combinationally so outputs are quiet for the whole reset window.
    assign clr_we_o    = rst_n && (state_q == CLEAR);
    assign clr_addr_o  = cnt_q;
    assign ready_o     = rst_n && (state_q == READY);
    assign init_busy_o = !rst_n || (state_q == CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD combinational
// read ports, x0 hardwired to zero. Build macro REGFILE_BYPASS_EN adds
// same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [XLEN-1:0]        wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [XLEN-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic                   init_busy
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            ready;
    logic [XLEN-1:0] mem_q [NREGS];

    regfile_clear_ctl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctl (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .ready_o     (ready),
        .init_busy_o (init_busy)
    );

    // NOTE: the array has no reset branch; the clear engine zeroes it so it can map to plain storage.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (ready) begin
            if (we0 && waddr0 != '0) mem_q[waddr0] <= wdata0;
            // Port 1 is the younger instruction: its later assignment wins on a clash.
            if (we1 && waddr1 != '0) mem_q[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[lane_lo(k, AW) +: AW];

        always_comb begin
            rd = '0;
            if (ready && ra != '0) begin
                rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (we0 && waddr0 == ra) rd = wdata0;
                if (we1 && waddr1 == ra) rd = wdata1;
`endif
            end
        end

        assign rdata[lane_lo(k, XLEN) +: XLEN] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (XLEN=64, NREGS=32, NUM_RD=2).
module tb_regfile_mp;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   we0, we1;
    logic [AW-1:0]          waddr0, waddr1;
    logic [XLEN-1:0]        wdata0, wdata1;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic                   init_busy;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        @(negedge clk);
        we0 = e0; waddr0 = a0; wdata0 = d0;
        we1 = e1; waddr1 = a1; wdata1 = d1;
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
    endtask

    // Holds reset low for n sampled edges, checking the in-reset outputs, then releases it.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rd(5'd3, 5'd0);
        check("busy_in_reset", XLEN'(init_busy), 64'd1);
        check("rdata_in_reset", rdata[XLEN-1:0], 64'd0);
        rst_n = 1'b1;
    endtask

    // Counts negedges with init_busy high from release; optionally issues a
    // port-0 write at busy cycle wr_at. Bounded at 100 cycles.
    task automatic wait_ready(output int n, input int wr_at, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        n = 0;
        while (init_busy && n < 100) begin
            if (n == wr_at) begin
                we0 = 1'b1; waddr0 = a; wdata0 = d;
            end
            @(negedge clk);
            we0 = 1'b0;
            n++;
            if (n == 15) begin
                rd(5'd1, 5'd31);
                check("clear_read_zero", rdata[XLEN-1:0], 64'd0);
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        raddr = '0;

        // 1. Reset, clear, pre-fill with 0xDEAD, reset again, verify all zero.
        do_reset(2);
        wait_ready(n, -1, '0, '0);
        check("busy_len_first", XLEN'(n), 64'd31);
        wr(1'b1, 5'd5,  64'hDEAD, 1'b1, 5'd31, 64'hDEAD);
        wr(1'b1, 5'd1,  64'hDEAD, 1'b1, 5'd17, 64'hDEAD);
        rd(5'd31, 5'd5);
        check("prefill_x31", rdata[XLEN-1:0], 64'hDEAD);
        check("prefill_x5", rdata[2*XLEN-1:XLEN], 64'hDEAD);
        do_reset(2);
        wait_ready(n, -1, '0, '0);
        check("busy_len_reset", XLEN'(n), 64'd31);
        for (int a = 0; a < NREGS; a++) begin
            rd(AW'(a), AW'(NREGS - 1 - a));
            check($sformatf("cleared_l0_x%0d", a), rdata[XLEN-1:0], 64'd0);
            check($sformatf("cleared_l1_x%0d", NREGS - 1 - a), rdata[2*XLEN-1:XLEN], 64'd0);
        end

        // 2. Basic write and read.
        wr(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 64'd0);
        rd(5'd5, 5'd0);
        check("basic_x5", rdata[XLEN-1:0], 64'h0123_4567_89AB_CDEF);
        check("basic_x0", rdata[2*XLEN-1:XLEN], 64'd0);

        // 3. Same-address conflict, then two distinct addresses together.
        wr(1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 64'h22);
        rd(5'd7, 5'd7);
        check("conflict_x7_l0", rdata[XLEN-1:0], 64'h22);
        check("conflict_x7_l1", rdata[2*XLEN-1:XLEN], 64'h22);
        wr(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB);
        rd(5'd3, 5'd4);
        check("dual_x3", rdata[XLEN-1:0], 64'hAA);
        check("dual_x4", rdata[2*XLEN-1:XLEN], 64'hBB);

        // 4. Writes to x0 are dropped.
        wr(1'b1, 5'd0, 64'h1234, 1'b1, 5'd0, '1);
        rd(5'd0, 5'd0);
        check("x0_l0", rdata[XLEN-1:0], 64'd0);
        check("x0_l1", rdata[2*XLEN-1:XLEN], 64'd0);

        // 5. Read of x9 in the same cycle it is written.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 64'h55;
        rd(5'd9, 5'd5);
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rdata[XLEN-1:0], 64'h55);
`else
        check("bypass_same_cycle", rdata[XLEN-1:0], 64'd0);
`endif
        check("bypass_other_lane", rdata[2*XLEN-1:XLEN], 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        we0 = 1'b0;
        rd(5'd9, 5'd9);
        check("bypass_next_cycle", rdata[XLEN-1:0], 64'h55);

        // 6. Reset at clear cycle 10, fresh clear; a write during busy is dropped.
        do_reset(1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n, 20, 5'd2, 64'h77);
        check("busy_len_restart", XLEN'(n), 64'd31);
        rd(5'd2, 5'd9);
        check("busy_write_dropped_x2", rdata[XLEN-1:0], 64'd0);
        check("restart_cleared_x9", rdata[2*XLEN-1:XLEN], 64'd0);
        wr(1'b1, 5'd2, 64'h77, 1'b0, 5'd0, 64'd0);
        rd(5'd2, 5'd0);
        check("post_ready_x2", rdata[XLEN-1:0], 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
